// File: rtl/hlcp_frame_assembler.sv
// hlcp_frame_assembler: deframes host bytes into CMD, Operand_ID and 48-bit data words
// with checksum, address match and inter-byte timeout.
module hlcp_frame_assembler #(
   parameter logic [4:0] ROW         = 5'b0,
   parameter logic [2:0] COLUMN      = 3'b0,
   parameter int         TIMEOUT_CYC = 1024
) (
   input  logic        sys_clk,
   input  logic        sys_resetb,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [3:0]  CMD,
   output logic [7:0]  Operand_ID,
   output logic [47:0] DATA_o,
   output logic [1:0]  loop_count,
   output logic        data_valid,
   output logic        init,
   output logic        CTS,
   output logic        error_flag
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_OPID, S_DATA, S_CHK} state_t;
   state_t      state_q, state_d;
   logic        rdy_q;
   logic [3:0]  cmd_q, cmd_d;
   logic [7:0]  opid_q, opid_d;
   logic [1:0]  nw_q, nw_d;
   logic        match_q, match_d;
   logic [7:0]  chk_q, chk_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic [1:0]  wcnt_q, wcnt_d;
   logic [39:0] sh_q, sh_d;
   logic [47:0] data_q, data_d;
   logic [1:0]  loop_q, loop_d;
   logic        dv_q, dv_d, init_q, init_d, cts_q, cts_d, err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic        acc, tmo_hit;
   // The registered ready gates acceptance, so the FSM leaves reset synchronously.
   assign acc     = rx_valid & rdy_q;
   assign tmo_hit = (state_q != S_IDLE) && !acc && (tmo_q == TW'(TIMEOUT_CYC - 1));
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      opid_d  = opid_q;
      nw_d    = nw_q;
      match_d = match_q;
      chk_d   = chk_q;
      bcnt_d  = bcnt_q;
      wcnt_d  = wcnt_q;
      sh_d    = sh_q;
      data_d  = data_q;
      loop_d  = loop_q;
      dv_d    = 1'b0;
      init_d  = 1'b0;
      cts_d   = 1'b0;
      err_d   = 1'b0;
      tmo_d   = (state_q == S_IDLE || acc) ? '0 : tmo_q + TW'(1);
      if (tmo_hit) begin
         state_d = S_IDLE;
         err_d   = match_q || state_q == S_HDR || state_q == S_OPID;
      end else if (acc) begin
         case (state_q)
            S_IDLE: state_d = (rx_data == 8'hA5) ? S_HDR : S_IDLE;
            S_HDR: begin
               cmd_d   = rx_data[7:4];
               nw_d    = rx_data[1:0];
               chk_d   = rx_data;
               err_d   = rx_data[3:2] != 2'b00;
               state_d = err_d ? S_IDLE : S_OPID;
            end
            S_OPID: begin
               opid_d  = rx_data;
               match_d = (rx_data == {ROW, COLUMN}) || (rx_data == 8'hFF);
               init_d  = match_d;
               chk_d   = chk_q ^ rx_data;
               bcnt_d  = 3'd0;
               wcnt_d  = 2'd0;
               state_d = S_DATA;
            end
            S_DATA: begin
               chk_d = chk_q ^ rx_data;
               if (bcnt_q == 3'd5) begin
                  if (match_q) begin
                     data_d = {sh_q, rx_data};
                     loop_d = wcnt_q;
                     dv_d   = 1'b1;
                  end
                  bcnt_d  = 3'd0;
                  wcnt_d  = wcnt_q + 2'd1;
                  state_d = (wcnt_q == nw_q) ? S_CHK : S_DATA;
               end else begin
                  sh_d   = {sh_q[31:0], rx_data};
                  bcnt_d = bcnt_q + 3'd1;
               end
            end
            S_CHK: begin
               cts_d   = match_q && (rx_data == chk_q);
               err_d   = match_q && (rx_data != chk_q);
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end
   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         state_q <= S_IDLE;
         rdy_q   <= 1'b0;
         cmd_q   <= '0;
         opid_q  <= '0;
         nw_q    <= '0;
         match_q <= 1'b0;
         chk_q   <= '0;
         bcnt_q  <= '0;
         wcnt_q  <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         loop_q  <= '0;
         dv_q    <= 1'b0;
         init_q  <= 1'b0;
         cts_q   <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         cmd_q   <= cmd_d;
         opid_q  <= opid_d;
         nw_q    <= nw_d;
         match_q <= match_d;
         chk_q   <= chk_d;
         bcnt_q  <= bcnt_d;
         wcnt_q  <= wcnt_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         loop_q  <= loop_d;
         dv_q    <= dv_d;
         init_q  <= init_d;
         cts_q   <= cts_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end
   assign rx_ready   = rdy_q;
   assign CMD        = cmd_q;
   assign Operand_ID = opid_q;
   assign DATA_o     = data_q;
   assign loop_count = loop_q;
   assign data_valid = dv_q;
   assign init       = init_q;
   assign CTS        = cts_q;
   assign error_flag = err_q;
endmodule

// File: tb/tb_hlcp_frame_assembler.sv
// tb_hlcp_frame_assembler: directed frames; expected strobes are queued with their cycle
// and a negedge monitor pops and compares them as the DUT raises them.
module tb_hlcp_frame_assembler;
   localparam int T = 16;
   logic        sys_clk = 1'b0;
   logic        sys_resetb = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready, data_valid, init, CTS, error_flag;
   logic [3:0]  CMD;
   logic [7:0]  Operand_ID;
   logic [47:0] DATA_o;
   logic [1:0]  loop_count;
   hlcp_frame_assembler #(.ROW(5'b0), .COLUMN(3'b0), .TIMEOUT_CYC(T)) dut (
      .sys_clk(sys_clk), .sys_resetb(sys_resetb), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .CMD(CMD), .Operand_ID(Operand_ID), .DATA_o(DATA_o),
      .loop_count(loop_count), .data_valid(data_valid), .init(init), .CTS(CTS),
      .error_flag(error_flag)
   );
   always #5 sys_clk = ~sys_clk;
   typedef struct {int kind; int cyc; logic [47:0] data; logic [1:0] lc;} exp_t;
   exp_t  q[$];
   exp_t  mon_e;
   logic [3:0] mon_s;
   int    cyc = 0, last_cyc = 0, errors = 0, checks = 0;
   string nm[4] = '{"init", "data_valid", "CTS", "error_flag"};
   always @(posedge sys_clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      rx_valid = 1'b0;
      last_cyc = cyc;
   endtask
   task automatic push(input int k, input logic [47:0] d, input logic [1:0] l, input int dly);
      q.push_back('{k, last_cyc + dly, d, l});
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 60) begin
         @(posedge sys_clk);
         n++;
      end
      repeat (3) @(posedge sys_clk);
      #1;
      chk("drain", q.size(), 0);
   endtask
   task automatic frame1(input logic [7:0] c, input bit good);
      logic [47:0] w = 48'h112233445566;
      send(8'hA5);
      send(8'h10);
      send(8'h00);
      push(0, 0, 0, 0);
      for (int i = 5; i >= 0; i--) send(w[i*8 +: 8]);
      push(1, w, 2'd0, 0);
      send(c);
      push(good ? 2 : 3, 0, 0, 0);
   endtask
   always @(negedge sys_clk) begin
      mon_s = {error_flag, CTS, data_valid, init};
      for (int k = 0; k < 4; k++) if (mon_s[k]) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: strobe at cycle %0d, required none", nm[k], cyc);
         end else begin
            mon_e = q.pop_front();
            if (mon_e.kind != k || mon_e.cyc != cyc ||
                (k == 1 && (DATA_o !== mon_e.data || loop_count !== mon_e.lc))) begin
               errors++;
               $display("FAIL event: got %s cyc %0d data %h lc %0d, required %s cyc %0d data %h lc %0d",
                        nm[k], cyc, DATA_o, loop_count, nm[mon_e.kind], mon_e.cyc, mon_e.data, mon_e.lc);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic [47:0] w;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_data", DATA_o, 0);
      chk("rst_ctrl", {rx_ready, CMD, Operand_ID, loop_count, data_valid, init, CTS, error_flag}, 0);
      sys_resetb = 1'b1;
      #1;
      chk("ready_lag", rx_ready, 0);
      @(posedge sys_clk);
      #1;
      chk("ready_up", rx_ready, 1);
      send(8'h00);
      send(8'h5A);
      frame1(8'h67, 1'b1);
      drain();
      chk("cmd_good", CMD, 4'h1);
      chk("opid_good", Operand_ID, 8'h00);
      frame1(8'h68, 1'b0);
      drain();
      send(8'hA5);
      send(8'h13);
      send(8'hFF);
      push(0, 0, 0, 0);
      w = '0;
      for (int i = 1; i <= 24; i++) begin
         send(8'(i));
         w = {w[39:0], 8'(i)};
         if (i % 6 == 0) push(1, w, 2'(i / 6 - 1), 0);
      end
      send(8'hF4);
      push(2, 0, 0, 0);
      send(8'hA5);
      send(8'h20);
      send(8'h00);
      push(0, 0, 0, 0);
      w = 48'hAABBCCDDEEFF;
      for (int i = 5; i >= 0; i--) send(w[i*8 +: 8]);
      push(1, w, 2'd0, 0);
      send(8'h31);
      push(2, 0, 0, 0);
      drain();
      chk("cmd_b2b", CMD, 4'h2);
      send(8'hA5);
      send(8'h30);
      send(8'h00);
      push(0, 0, 0, 0);
      send(8'h11);
      send(8'h22);
      sys_resetb = 1'b0;
      #1;
      chk("midrst_data", DATA_o, 0);
      chk("midrst_ctrl", {rx_ready, CMD, Operand_ID, loop_count, data_valid, init, CTS, error_flag}, 0);
      repeat (2) @(posedge sys_clk);
      #1;
      sys_resetb = 1'b1;
      @(posedge sys_clk);
      #1;
      frame1(8'h67, 1'b1);
      drain();
      send(8'hA5);
      send(8'h10);
      send(8'h05);
      for (int i = 0; i < 6; i++) send(8'h40 + 8'(i));
      send(8'h99);
      drain();
      chk("nm_opid", Operand_ID, 8'h05);
      chk("nm_data", DATA_o, 48'h112233445566);
      send(8'hA5);
      send(8'h1C);
      push(3, 0, 0, 0);
      drain();
      send(8'hA5);
      send(8'h10);
      send(8'h00);
      push(0, 0, 0, 0);
      send(8'h11);
      send(8'h22);
      push(3, 0, 0, T);
      repeat (T + 4) @(posedge sys_clk);
      #1;
      drain();
      frame1(8'h67, 1'b1);
      drain();
      chk("final_data", DATA_o, 48'h112233445566);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
